branch_seq_ctrl: RTL and testbench

BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

---
 rtl/branch_pkg.sv | 32 +++
 rtl/branch_cond_eval.sv | 23 ++
 rtl/branch_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_branch_seq_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencing controller: FSM states, branch
// opcodes, ALU operation codes and datapath mux selects.
package branch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_TARGET  = 3'd2,
        ST_COMPARE = 3'd3,
        ST_RESOLVE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        BR_BEQ = 2'b00,
        BR_BNE = 2'b01,
        BR_BLE = 2'b10,
        BR_BGT = 2'b11
    } br_op_t;

    localparam logic [2:0] ALU_IDLE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_REG    = 2'b01;
    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_OFFSET = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition decode: maps the latched opcode and the ALU flags captured
// during COMPARE onto a single taken/not-taken decision.
module branch_cond_eval
    import branch_pkg::*;
(
    input  br_op_t br_op,
    input  logic   igual,
    input  logic   maior,
    output logic   cond
);

    always_comb begin
        cond = 1'b0;
        case (br_op)
            BR_BEQ:  cond = igual;
            BR_BNE:  cond = !igual;
            BR_BLE:  cond = !maior;
            BR_BGT:  cond = maior;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Multi-cycle conditional branch sequencer: LOAD, TARGET, COMPARE, RESOLVE
// with registered Moore outputs and saturating branch statistics.
module branch_seq_ctrl
    import branch_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       br_op,
    input  logic             igual,
    input  logic             maior,
    output logic             busy,
    output logic             done,
    output logic             regs_load,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic             alu_out_load,
    output logic [1:0]       pc_source,
    output logic             pc_write,
    output logic             taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    state_t state;
    br_op_t op_q;
    logic   igual_q;
    logic   maior_q;
    logic   cond;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    branch_cond_eval u_cond_eval (
        .br_op (op_q),
        .igual (igual_q),
        .maior (maior_q),
        .cond  (cond)
    );

    // done is only high in RESOLVE, so gating with it keeps pc_write a pure
    // function of state plus the flags captured at the end of COMPARE.
    assign pc_write = done & cond;

    // Outputs are loaded with the decode of the state being entered, so they
    // line up exactly with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            op_q         <= BR_BEQ;
            igual_q      <= 1'b0;
            maior_q      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            regs_load    <= 1'b0;
            alu_src_a    <= SRC_A_PC;
            alu_src_b    <= SRC_B_REG;
            alu_op       <= ALU_IDLE;
            alu_out_load <= 1'b0;
            pc_source    <= PC_SRC_ALU;
            taken        <= 1'b0;
            branch_count <= '0;
            taken_count  <= '0;
        end else begin
            done         <= 1'b0;
            regs_load    <= 1'b0;
            alu_src_a    <= SRC_A_PC;
            alu_src_b    <= SRC_B_REG;
            alu_op       <= ALU_IDLE;
            alu_out_load <= 1'b0;
            pc_source    <= PC_SRC_ALU;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_LOAD;
                        op_q      <= br_op_t'(br_op);
                        busy      <= 1'b1;
                        regs_load <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state        <= ST_TARGET;
                    alu_src_a    <= SRC_A_PC;
                    alu_src_b    <= SRC_B_OFFSET;
                    alu_op       <= ALU_ADD;
                    alu_out_load <= 1'b1;
                end
                ST_TARGET: begin
                    state     <= ST_COMPARE;
                    alu_src_a <= SRC_A_REG;
                    alu_src_b <= SRC_B_REG;
                    alu_op    <= ALU_SUB;
                end
                ST_COMPARE: begin
                    state     <= ST_RESOLVE;
                    igual_q   <= igual;
                    maior_q   <= maior;
                    done      <= 1'b1;
                    pc_source <= PC_SRC_ALUOUT;
                end
                ST_RESOLVE: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    taken        <= cond;
                    branch_count <= sat_inc(branch_count);
                    if (cond) begin
                        taken_count <= sat_inc(taken_count);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Randomized and directed bench for branch_seq_ctrl; a transaction-level model
// predicts every output, with a 16-bit and a 2-bit counter instance in parallel.
module tb_branch_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] br_op;
    logic       igual;
    logic       maior;

    logic        busy, done, regs_load, alu_out_load, pc_write, taken;
    logic [1:0]  alu_src_a, alu_src_b, pc_source;
    logic [2:0]  alu_op;
    logic [15:0] branch_count, taken_count;

    logic        s_busy, s_done, s_regs_load, s_alu_out_load, s_pc_write, s_taken;
    logic [1:0]  s_alu_src_a, s_alu_src_b, s_pc_source;
    logic [2:0]  s_alu_op;
    logic [1:0]  s_branch_count, s_taken_count;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;

    // model: position inside a branch (0 = idle, 1..4 = cycles since accept)
    int         pos;
    logic [1:0] m_op;
    logic       m_ig, m_ma, m_taken;
    int         m_bc, m_tc, m_bc2, m_tc2;

    branch_seq_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .br_op(br_op),
        .igual(igual), .maior(maior), .busy(busy), .done(done),
        .regs_load(regs_load), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .alu_out_load(alu_out_load), .pc_source(pc_source),
        .pc_write(pc_write), .taken(taken), .branch_count(branch_count),
        .taken_count(taken_count)
    );

    branch_seq_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .start(start), .br_op(br_op),
        .igual(igual), .maior(maior), .busy(s_busy), .done(s_done),
        .regs_load(s_regs_load), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
        .alu_op(s_alu_op), .alu_out_load(s_alu_out_load), .pc_source(s_pc_source),
        .pc_write(s_pc_write), .taken(s_taken), .branch_count(s_branch_count),
        .taken_count(s_taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rule(input logic [1:0] op, input logic ig, input logic ma);
        case (op)
            2'd0:    return ig;
            2'd1:    return !ig;
            2'd2:    return !ma;
            default: return ma;
        endcase
    endfunction

    task automatic model_reset();
        pos = 0; m_op = 2'd0; m_ig = 1'b0; m_ma = 1'b0; m_taken = 1'b0;
        m_bc = 0; m_tc = 0; m_bc2 = 0; m_tc2 = 0;
    endtask

    task automatic model_tick();
        logic c;
        if (pos == 0) begin
            if (start) begin
                pos  = 1;
                m_op = br_op;
            end
        end else if (pos == 3) begin
            m_ig = igual;
            m_ma = maior;
            pos  = 4;
        end else if (pos == 4) begin
            c       = rule(m_op, m_ig, m_ma);
            m_taken = c;
            if (m_bc < 65535) m_bc++;
            if (m_bc2 < 3) m_bc2++;
            if (c && m_tc < 65535) m_tc++;
            if (c && m_tc2 < 3) m_tc2++;
            pos = 0;
        end else begin
            pos++;
        end
    endtask

    task automatic check_outputs();
        logic pw;
        pw = (pos == 4) && rule(m_op, m_ig, m_ma);
        chk("busy",         busy,         (pos != 0));
        chk("done",         done,         (pos == 4));
        chk("regs_load",    regs_load,    (pos == 1));
        chk("alu_src_a",    alu_src_a,    (pos == 3) ? 2'b01 : 2'b00);
        chk("alu_src_b",    alu_src_b,    (pos == 2) ? 2'b11 : 2'b00);
        chk("alu_op",       alu_op,       (pos == 2) ? 3'b001 : (pos == 3) ? 3'b010 : 3'b000);
        chk("alu_out_load", alu_out_load, (pos == 2));
        chk("pc_source",    pc_source,    (pos == 4) ? 2'b01 : 2'b00);
        chk("pc_write",     pc_write,     pw);
        chk("taken",        taken,        m_taken);
        chk("branch_count", branch_count, m_bc);
        chk("taken_count",  taken_count,  m_tc);
        chk("s_busy",       s_busy,       (pos != 0));
        chk("s_pc_write",   s_pc_write,   pw);
        chk("s_branch_cnt", s_branch_count, m_bc2);
        chk("s_taken_cnt",  s_taken_count,  m_tc2);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_ctrl"},  {regs_load, alu_src_a, alu_src_b, alu_op, alu_out_load, pc_source}, 0);
        chk({tag, "_pcw"},   pc_write, 0);
        chk({tag, "_taken"}, taken, 0);
        chk({tag, "_bc"},    branch_count, 0);
        chk({tag, "_tc"},    taken_count, 0);
        chk({tag, "_small"}, {s_busy, s_done, s_pc_write, s_taken, s_branch_count, s_taken_count}, 0);
    endtask

    task automatic cycle(input logic s, input logic [1:0] op, input logic ig, input logic ma);
        @(negedge clk);
        check_outputs();
        if (done) n_done++;
        start = s; br_op = op; igual = ig; maior = ma;
        @(posedge clk);
        model_tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; br_op = 2'd0; igual = 1'b0; maior = 1'b0;
        model_reset();
        #12;
        check_all_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // BEQ taken: igual=1 only while COMPARE
        cycle(1, 2'd0, 0, 0); cycle(0, 2'd0, 0, 0); cycle(0, 2'd0, 0, 0);
        cycle(0, 2'd0, 1, 0); cycle(0, 2'd0, 0, 0); cycle(0, 2'd0, 0, 0);

        // BLE not taken: maior=1 in COMPARE, igual toggling around it
        cycle(1, 2'd2, 1, 0); cycle(0, 2'd2, 0, 0); cycle(0, 2'd2, 1, 0);
        cycle(0, 2'd2, 0, 1); cycle(0, 2'd2, 1, 0); cycle(0, 2'd2, 0, 0);

        // start held for 10 cycles: two back-to-back sequences
        n_done = 0;
        for (int i = 0; i < 10; i++)
            cycle(1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cycle(0, 2'd0, 0, 0);
        chk("hold_two_seq", n_done, 2);

        // five taken BGT branches saturate the 2-bit counters
        for (int i = 0; i < 5; i++) begin
            cycle(1, 2'd3, 0, 0); cycle(0, 2'd3, 0, 0); cycle(0, 2'd3, 0, 0);
            cycle(0, 2'd3, 0, 1); cycle(0, 2'd3, 0, 0);
        end
        cycle(0, 2'd0, 0, 0);
        chk("sat_small_bc", s_branch_count, 3);
        chk("sat_small_tc", s_taken_count, 3);

        // asynchronous reset in the middle of COMPARE
        cycle(1, 2'd0, 0, 0); cycle(0, 2'd0, 0, 0); cycle(0, 2'd0, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cycle(0, 2'd0, 1, 1);

        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        cycle(0, 2'd0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
